// File: rtl/div_ctrl.sv
// div_ctrl -- multi-cycle 32-bit integer divider controller for the EX stage.
//
// Purpose:
//   Accepts a division request, runs one restoring radix-2 step per clock on
//   the operand magnitudes, applies the sign correction and presents
//   {remainder, quotient} until the requester drops start_i. The request can
//   be cancelled at any time with annul_i.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   signed_i    in   1   1 = signed division, 0 = unsigned
//   dividend_i  in   32  dividend operand
//   divider_i   in   32  divisor operand
//   start_i     in   1   request, held high until success_o is seen
//   annul_i     in   1   cancel (pipeline flush / exception)
//   result_o    out  64  {remainder[63:32], quotient[31:0]}, zero unless done
//   success_o   out  1   result_o valid
//   busy_o      out  1   high whenever a request is being handled
//
// Configuration:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor finishes one edge after
//                     accept with a zero result instead of running 32 steps.

module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divider_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        success_o,
  output logic        busy_o
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {FREE, DIVZERO, ON, END} state_e;
`else
  typedef enum logic [1:0] {FREE, ON, END} state_e;
`endif

  state_e      state_q;
  logic [5:0]  count_q;
  logic        signed_q;
  logic        dividendNeg_q;
  logic        dividerNeg_q;
  logic [31:0] divisor_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [63:0] result_q;
  logic        success_q;
  logic        busy_q;

  logic [31:0] dividendMag;
  logic [31:0] dividerMag;
  logic [32:0] partialRem;
  logic [32:0] trialDiff;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] remFixed;
  logic [31:0] quoFixed;
  logic        abortReq;

  // Magnitudes of the incoming operands. The most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude, so no overflow
  // special case is needed for 0x80000000 / 0xFFFFFFFF.
  assign dividendMag = (signed_i && dividend_i[31]) ? (~dividend_i + 32'd1) : dividend_i;
  assign dividerMag  = (signed_i && divider_i[31])  ? (~divider_i + 32'd1)  : divider_i;

  // Leaving a busy state happens on cancel or when the requester gives up.
  assign abortReq = annul_i || !start_i;

  // One restoring step: bring the next dividend bit into the partial
  // remainder and keep the trial difference only if it did not borrow.
  // The partial remainder stays below twice the divisor, so 33 bits suffice.
  // A zero divisor never borrows, giving an all-ones quotient and the
  // dividend as remainder.
  always_comb begin
    partialRem = {rem_q, quo_q[31]};
    trialDiff  = partialRem - {1'b0, divisor_q};
    if (!trialDiff[32]) begin
      rem_d = trialDiff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = partialRem[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
    quoFixed = (signed_q && (dividendNeg_q ^ dividerNeg_q)) ? (~quo_d + 32'd1) : quo_d;
    remFixed = (signed_q && dividendNeg_q) ? (~rem_d + 32'd1) : rem_d;
  end

  // Control FSM. All outputs are registers updated alongside the state so
  // they never glitch; result_q is only non-zero while in END.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FREE;
      count_q       <= 6'd0;
      signed_q      <= 1'b0;
      dividendNeg_q <= 1'b0;
      dividerNeg_q  <= 1'b0;
      divisor_q     <= 32'd0;
      rem_q         <= 32'd0;
      quo_q         <= 32'd0;
      result_q      <= 64'd0;
      success_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          result_q  <= 64'd0;
          success_q <= 1'b0;
          if (start_i && !annul_i) begin
            // Operands are captured once here; later input changes are
            // ignored until the next pass through FREE.
            signed_q      <= signed_i;
            dividendNeg_q <= dividend_i[31];
            dividerNeg_q  <= divider_i[31];
            divisor_q     <= dividerMag;
            rem_q         <= 32'd0;
            quo_q         <= dividendMag;
            count_q       <= 6'd0;
            busy_q        <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            state_q       <= (divider_i == 32'd0) ? DIVZERO : ON;
`else
            state_q       <= ON;
`endif
          end
        end

`ifdef DIV_ZERO_FAST_EN
        DIVZERO: begin
          if (abortReq) begin
            state_q <= FREE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= END;
            result_q  <= 64'd0;
            success_q <= 1'b1;
          end
        end
`endif

        ON: begin
          if (abortReq) begin
            state_q <= FREE;
            busy_q  <= 1'b0;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + 6'd1;
            // The 32nd step's output goes straight into the sign fix so the
            // result is available 32 edges after the accepting edge.
            if (count_q == 6'd31) begin
              result_q  <= {remFixed, quoFixed};
              success_q <= 1'b1;
              state_q   <= END;
            end
          end
        end

        END: begin
          if (abortReq) begin
            state_q   <= FREE;
            result_q  <= 64'd0;
            success_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q   <= FREE;
          result_q  <= 64'd0;
          success_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign result_o  = result_q;
  assign success_o = success_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl -- self-checking bench for div_ctrl.
//
// A transaction-level model predicts busy/success/result every cycle from
// plain arithmetic and a countdown; a compare process checks the DUT against
// it on each falling edge. Directed tests add hand-computed literals for
// results and latencies.
// Honours DIV_ZERO_FAST_EN the same way the design does.

module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divider_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        success_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  bit compareEn = 1'b0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divider_i  (divider_i),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .success_o  (success_o),
    .busy_o     (busy_o)
  );

  // Reference arithmetic: quotient and remainder from ordinary integer
  // division on 64-bit values, signs applied afterwards.
  function automatic logic [63:0] calcExpected(input logic sgn,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint ma, mb, q, r;
    if (sgn) begin
      ma = longint'($signed(a));
      mb = longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'({32'd0, a});
      mb = longint'({32'd0, b});
    end
    if (mb == 0) begin
      q = 64'h00000000_FFFFFFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle-level behavioural model of the request protocol.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
  mphase_e     mPhase   = M_IDLE;
  int          mLeft    = 0;
  logic [63:0] mPending = 64'd0;
  logic [63:0] mResult  = 64'd0;
  logic        mSuccess = 1'b0;
  logic        mBusy    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = M_IDLE; mLeft = 0; mResult = 64'd0; mSuccess = 1'b0; mBusy = 1'b0;
    end else begin
      case (mPhase)
        M_IDLE: if (start_i && !annul_i) begin
          mPending = calcExpected(signed_i, dividend_i, divider_i);
          mLeft    = 32;
`ifdef DIV_ZERO_FAST_EN
          if (divider_i == 32'd0) begin
            mPending = 64'd0;
            mLeft    = 1;
          end
`endif
          mPhase = M_RUN;
          mBusy  = 1'b1;
        end
        M_RUN: if (annul_i || !start_i) begin
          mPhase = M_IDLE; mBusy = 1'b0; mSuccess = 1'b0; mResult = 64'd0;
        end else begin
          mLeft = mLeft - 1;
          if (mLeft == 0) begin
            mPhase = M_DONE; mSuccess = 1'b1; mResult = mPending;
          end
        end
        M_DONE: if (annul_i || !start_i) begin
          mPhase = M_IDLE; mBusy = 1'b0; mSuccess = 1'b0; mResult = 64'd0;
        end
        default: mPhase = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (compareEn && !rst) begin
      checkOutput("cyc_result",  result_o, mResult);
      checkOutput("cyc_success", {63'd0, success_o}, {63'd0, mSuccess});
      checkOutput("cyc_busy",    {63'd0, busy_o},    {63'd0, mBusy});
    end
  end

  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic st,
                               input logic an);
    @(negedge clk);
    signed_i   = sgn;
    dividend_i = a;
    divider_i  = b;
    start_i    = st;
    annul_i    = an;
  endtask

  // Wait (bounded) for success_o; returns edges elapsed since accept,
  // assuming the caller is at the falling edge right after the accept edge.
  task automatic waitSuccess(output int k);
    k = 0;
    while (!success_o && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic runDiv(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expRes,
                        input int expEdges);
    int k;
    applyStimulus(sgn, a, b, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput({name, "_busy"}, {63'd0, busy_o}, 64'd1);
    // Scramble inputs after accept; they must be ignored.
    dividend_i = ~a;
    divider_i  = b + 32'd7;
    signed_i   = ~sgn;
    waitSuccess(k);
    checkOutput({name, "_edges"}, 64'(k), 64'(expEdges));
    checkOutput({name, "_result"}, result_o, expRes);
    checkOutput({name, "_model"}, mResult, expRes);
    @(negedge clk);
    checkOutput({name, "_hold"}, {result_o[62:0], success_o}, {expRes[62:0], 1'b1});
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput({name, "_release"}, {result_o[61:0], success_o, busy_o}, 64'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; signed_i = 1'b0; dividend_i = 32'd0; divider_i = 32'd0;
    start_i = 1'b0; annul_i = 1'b0;
    #12;
    checkOutput("reset_outputs", {result_o[61:0], success_o, busy_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    compareEn = 1'b1;

    runDiv("u_100_7",     1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
    runDiv("s_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32);
    runDiv("s_min_m1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32);
    runDiv("s_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
    runDiv("u_fff9_2",    1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 32);
    runDiv("u_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 32);
`ifdef DIV_ZERO_FAST_EN
    runDiv("u_div0",      1'b0, 32'h1234,       32'd0,          64'h0, 1);
`else
    runDiv("u_div0",      1'b0, 32'h1234,       32'd0,          64'h00001234_FFFFFFFF, 32);
`endif

    // Cancel at step 10 of 7/3, then a fresh 5/5.
    applyStimulus(1'b0, 32'd7, 32'd3, 1'b1, 1'b0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    checkOutput("annul_free", {result_o[61:0], success_o, busy_o}, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("annul_quiet", {63'd0, success_o}, 64'd0);
    end
    runDiv("u_5_5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, 32);

    // Both start and annul in FREE: stays idle.
    applyStimulus(1'b0, 32'd5, 32'd1, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("both_high_idle", {63'd0, busy_o}, 64'd0);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Back-to-back: annul out of END with start held re-accepts after one FREE cycle.
    applyStimulus(1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
    @(negedge clk);
    waitSuccess(k);
    checkOutput("b2b_first", result_o, 64'h00000000_0000000A);
    dividend_i = 32'd61; divider_i = 32'd6; annul_i = 1'b1;
    @(negedge clk);
    checkOutput("b2b_free", {result_o[61:0], success_o, busy_o}, 64'd0);
    annul_i = 1'b0;
    @(negedge clk);
    checkOutput("b2b_reaccept", {63'd0, busy_o}, 64'd1);
    waitSuccess(k);
    checkOutput("b2b_edges", 64'(k), 64'd32);
    checkOutput("b2b_second", result_o, 64'h00000001_0000000A);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset at step 20, then 9/3.
    applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    @(negedge clk);
    repeat (20) @(negedge clk);
    checkOutput("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", {result_o[61:0], success_o, busy_o}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    runDiv("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32);

    compareEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
